// File: rtl/lpif_ll_credit_fifo_if.sv
// LPIF logic-link bundle between the user side and the PHY concat path.
// The slave modport is the link-layer block; the master modport is its environment.
interface lpif_ll_credit_fifo_if #(
  parameter int DATA_WIDTH = 562,
  parameter int DEPTH      = 16,
  parameter int CRED_WIDTH = 8
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic                  tx_online;
  logic                  rx_online;
  logic [CRED_WIDTH-1:0] init_upstream_credit;
  logic [DATA_WIDTH-1:0] user_tx_data;
  logic                  user_tx_valid;
  logic                  user_tx_ready;
  logic [DATA_WIDTH-1:0] tx_phy_data;
  logic                  tx_phy_push;
  logic                  rx_credit_in;
  logic [DATA_WIDTH-1:0] rx_phy_data;
  logic                  rx_phy_push;
  logic [DATA_WIDTH-1:0] user_rx_data;
  logic                  user_rx_valid;
  logic                  user_rx_ready;
  logic                  tx_credit_out;
  logic [LVL_W-1:0]      rx_fifo_level;
  logic [CRED_WIDTH-1:0] tx_credit_count;
  logic                  rx_overflow;
  logic                  tx_credit_overflow;
  logic [31:0]           debug_status;

  modport slave (
    input  tx_online, rx_online, init_upstream_credit,
    input  user_tx_data, user_tx_valid, rx_credit_in,
    input  rx_phy_data, rx_phy_push, user_rx_ready,
    output user_tx_ready, tx_phy_data, tx_phy_push,
    output user_rx_data, user_rx_valid, tx_credit_out,
    output rx_fifo_level, tx_credit_count, rx_overflow,
    output tx_credit_overflow, debug_status
  );

  modport master (
    output tx_online, rx_online, init_upstream_credit,
    output user_tx_data, user_tx_valid, rx_credit_in,
    output rx_phy_data, rx_phy_push, user_rx_ready,
    input  user_tx_ready, tx_phy_data, tx_phy_push,
    input  user_rx_data, user_rx_valid, tx_credit_out,
    input  rx_fifo_level, tx_credit_count, rx_overflow,
    input  tx_credit_overflow, debug_status
  );
endinterface

// File: rtl/lpif_ll_credit_fifo.sv
// LPIF logic-link layer: credit-gated TX path toward the concat block and a
// first-word-fall-through RX FIFO that returns one credit per consumed word.
module lpif_ll_credit_fifo #(
  parameter int DATA_WIDTH = 562,
  parameter int DEPTH      = 16,
  parameter int CRED_WIDTH = 8
) (
  input  logic                 clk_wr,
  input  logic                 rst_wr_n,
  lpif_ll_credit_fifo_if.slave lnk
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  // Saturating credit update: an increment at all-ones holds the count.
  function automatic logic [CRED_WIDTH-1:0] cred_step(
    input logic [CRED_WIDTH-1:0] c,
    input logic                  inc,
    input logic                  dec
  );
    if (inc && !dec)      cred_step = (&c) ? c : c + 1'b1;
    else if (dec && !inc) cred_step = c - 1'b1;
    else                  cred_step = c;
  endfunction

  logic                  tx_online_q;
  logic [CRED_WIDTH-1:0] cred_cnt;
  logic                  cred_ovf;
  logic                  tx_accept;
  logic                  tx_push_p1;
  logic [DATA_WIDTH-1:0] tx_data_p1;

  assign lnk.user_tx_ready = lnk.tx_online && (cred_cnt != '0);
  assign tx_accept         = lnk.user_tx_valid && lnk.user_tx_ready;

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      tx_online_q <= 1'b0;
      cred_cnt    <= '0;
      cred_ovf    <= 1'b0;
    end else begin
      tx_online_q <= lnk.tx_online;
      if (!lnk.tx_online) begin
        cred_cnt <= '0;
      end else if (!tx_online_q) begin
        cred_cnt <= lnk.init_upstream_credit;
      end else begin
        cred_cnt <= cred_step(cred_cnt, lnk.rx_credit_in, tx_accept);
        if (lnk.rx_credit_in && !tx_accept && (&cred_cnt))
          cred_ovf <= 1'b1;
      end
    end
  end

  // ---- TX stage p1: accepted word registered toward the concat block ----
  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      tx_push_p1 <= 1'b0;
      tx_data_p1 <= '0;
    end else begin
      tx_push_p1 <= tx_accept;
      if (tx_accept) tx_data_p1 <= lnk.user_tx_data;
    end
  end

  assign lnk.tx_phy_push = tx_push_p1;
  assign lnk.tx_phy_data = tx_data_p1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [LVL_W-1:0]      level;
  logic                  rx_ovf;
  logic                  credit_p1;
  logic                  full;
  logic                  rx_push;
  logic                  rx_pop;
  logic                  rx_wr;

  assign full              = (level == LVL_W'(DEPTH));
  assign lnk.user_rx_valid = (level != '0);
  assign rx_push           = lnk.rx_phy_push && lnk.rx_online;
  assign rx_pop            = lnk.user_rx_valid && lnk.user_rx_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the word.
  assign rx_wr             = rx_push && (!full || rx_pop);

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      rx_ovf    <= 1'b0;
      credit_p1 <= 1'b0;
    end else if (!lnk.rx_online) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      credit_p1 <= 1'b0;
    end else begin
      if (rx_wr)  wr_ptr <= wr_ptr + 1'b1;
      if (rx_pop) rd_ptr <= rd_ptr + 1'b1;
      level     <= level + {{PTR_W{1'b0}}, rx_wr} - {{PTR_W{1'b0}}, rx_pop};
      if (rx_push && full && !rx_pop) rx_ovf <= 1'b1;
      credit_p1 <= rx_pop;
    end
  end

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (rx_wr) begin
      mem[wr_ptr] <= lnk.rx_phy_data;
    end
  end

  assign lnk.user_rx_data       = mem[rd_ptr];
  assign lnk.tx_credit_out      = credit_p1;
  assign lnk.rx_fifo_level      = level;
  assign lnk.tx_credit_count    = cred_cnt;
  assign lnk.rx_overflow        = rx_ovf;
  assign lnk.tx_credit_overflow = cred_ovf;

  logic [7:0] cred8;
  logic [7:0] lvl8;

  if (CRED_WIDTH >= 8) begin : g_cred_trunc
    assign cred8 = cred_cnt[7:0];
  end else begin : g_cred_pad
    assign cred8 = {{(8-CRED_WIDTH){1'b0}}, cred_cnt};
  end

  if (LVL_W >= 8) begin : g_lvl_trunc
    assign lvl8 = level[7:0];
  end else begin : g_lvl_pad
    assign lvl8 = {{(8-LVL_W){1'b0}}, level};
  end

  assign lnk.debug_status = {rx_ovf, cred_ovf, 6'b0, cred8, lvl8, 6'b0,
                             lnk.tx_online, lnk.rx_online};
endmodule

// File: tb/tb_lpif_ll_credit_fifo.sv
// Directed plus randomized bench for lpif_ll_credit_fifo with a queue-based
// reference model of the credit counter and RX FIFO.
module tb_lpif_ll_credit_fifo;
  localparam int DW    = 64;
  localparam int DEPTH = 16;
  localparam int CW    = 8;
  localparam int CMAX  = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  lpif_ll_credit_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CRED_WIDTH(CW)) lnk ();

  lpif_ll_credit_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CRED_WIDTH(CW)) dut (
    .clk_wr  (clk),
    .rst_wr_n(rst_n),
    .lnk     (lnk)
  );

  // reference model state
  int            m_cnt;
  bit            m_cnt_ovf;
  bit            m_txon_prev;
  bit            m_rx_ovf;
  bit            m_push;
  bit            m_credit;
  logic [DW-1:0] m_data;
  logic [DW-1:0] m_q [$];
  int            push_seen;
  int            credit_seen;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_cnt_ovf = 0; m_txon_prev = 0; m_rx_ovf = 0;
    m_push = 0; m_credit = 0; m_data = '0; m_q.delete();
  endtask

  task automatic idle_inputs();
    lnk.tx_online = 0; lnk.rx_online = 0; lnk.init_upstream_credit = '0;
    lnk.user_tx_data = '0; lnk.user_tx_valid = 0; lnk.rx_credit_in = 0;
    lnk.rx_phy_data = '0; lnk.rx_phy_push = 0; lnk.user_rx_ready = 0;
  endtask

  function automatic logic [DW-1:0] rnd_word();
    return {$urandom, $urandom};
  endfunction

  task automatic chk_reset_outputs();
    chk("rst_tx_push",   lnk.tx_phy_push, 0);
    chk("rst_tx_data",   lnk.tx_phy_data, 0);
    chk("rst_rx_valid",  lnk.user_rx_valid, 0);
    chk("rst_credit",    lnk.tx_credit_out, 0);
    chk("rst_level",     lnk.rx_fifo_level, 0);
    chk("rst_count",     lnk.tx_credit_count, 0);
    chk("rst_rx_ovf",    lnk.rx_overflow, 0);
    chk("rst_cred_ovf",  lnk.tx_credit_overflow, 0);
    chk("rst_debug",     lnk.debug_status, {30'b0, lnk.tx_online, lnk.rx_online});
  endtask

  // One clock: check combinational outputs, advance model, check registered outputs.
  task automatic cycle();
    bit acc, pop, push;
    logic [7:0] c8, l8;
    #2;
    chk("tx_ready", lnk.user_tx_ready, (lnk.tx_online && m_cnt != 0));
    chk("rx_valid", lnk.user_rx_valid, (m_q.size() != 0));
    if (m_q.size() != 0) chk("rx_data", lnk.user_rx_data, m_q[0]);
    acc  = lnk.user_tx_valid && lnk.tx_online && (m_cnt != 0);
    pop  = lnk.user_rx_ready && (m_q.size() != 0);
    push = lnk.rx_phy_push && lnk.rx_online;
    if (!lnk.tx_online) m_cnt = 0;
    else if (!m_txon_prev) m_cnt = int'(lnk.init_upstream_credit);
    else if (lnk.rx_credit_in && !acc) begin
      if (m_cnt == CMAX) m_cnt_ovf = 1; else m_cnt++;
    end else if (acc && !lnk.rx_credit_in) m_cnt--;
    m_txon_prev = lnk.tx_online;
    m_push = acc;
    if (acc) m_data = lnk.user_tx_data;
    if (!lnk.rx_online) begin
      m_q.delete();
      m_credit = 0;
    end else begin
      m_credit = pop;
      if (pop) void'(m_q.pop_front());
      if (push) begin
        if (m_q.size() < DEPTH) m_q.push_back(lnk.rx_phy_data);
        else m_rx_ovf = 1;
      end
    end
    @(posedge clk);
    #1;
    c8 = m_cnt[7:0];
    l8 = 8'(m_q.size());
    chk("tx_push",   lnk.tx_phy_push, m_push);
    chk("tx_data",   lnk.tx_phy_data, m_data);
    chk("count",     lnk.tx_credit_count, m_cnt);
    chk("level",     lnk.rx_fifo_level, m_q.size());
    chk("credit_out", lnk.tx_credit_out, m_credit);
    chk("rx_ovf",    lnk.rx_overflow, m_rx_ovf);
    chk("cred_ovf",  lnk.tx_credit_overflow, m_cnt_ovf);
    chk("debug",     lnk.debug_status,
        {m_rx_ovf, m_cnt_ovf, 6'b0, c8, l8, 6'b0, lnk.tx_online, lnk.rx_online});
    if (lnk.tx_phy_push) push_seen++;
    if (lnk.tx_credit_out) credit_seen++;
  endtask

  initial begin
    int p0, c0;
    rst_n = 0;
    idle_inputs();
    model_reset();
    push_seen = 0; credit_seen = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs();
    rst_n = 1;

    // credit load and exhaustion
    lnk.init_upstream_credit = 8'd4;
    lnk.tx_online = 1;
    lnk.user_tx_valid = 1;
    p0 = push_seen;
    for (int i = 0; i < 10; i++) begin lnk.user_tx_data = rnd_word(); cycle(); end
    chk("exhaust_pushes", push_seen - p0, 4);
    chk("exhaust_count", lnk.tx_credit_count, 0);
    chk("exhaust_ready", lnk.user_tx_ready, 0);
    p0 = push_seen;
    lnk.rx_credit_in = 1; lnk.user_tx_data = rnd_word(); cycle();
    lnk.rx_credit_in = 0;
    for (int i = 0; i < 4; i++) begin lnk.user_tx_data = rnd_word(); cycle(); end
    chk("refill_pushes", push_seen - p0, 1);

    // simultaneous credit and accept at count 3
    lnk.tx_online = 0; lnk.user_tx_valid = 0; cycle();
    lnk.init_upstream_credit = 8'd3; lnk.tx_online = 1; cycle();
    chk("load3", lnk.tx_credit_count, 3);
    p0 = push_seen;
    lnk.user_tx_valid = 1; lnk.rx_credit_in = 1;
    for (int i = 0; i < 5; i++) begin lnk.user_tx_data = rnd_word(); cycle(); end
    lnk.user_tx_valid = 0; lnk.rx_credit_in = 0; cycle();
    chk("simul_pushes", push_seen - p0, 5);
    chk("simul_count", lnk.tx_credit_count, 3);

    // RX fill, overflow, drain
    lnk.rx_online = 1; lnk.rx_phy_push = 1; lnk.user_rx_ready = 0;
    c0 = credit_seen;
    for (int i = 0; i < 17; i++) begin lnk.rx_phy_data = rnd_word(); cycle(); end
    chk("fill_level", lnk.rx_fifo_level, 16);
    chk("fill_ovf", lnk.rx_overflow, 1);
    chk("fill_credits", credit_seen - c0, 0);
    lnk.rx_phy_push = 0; lnk.user_rx_ready = 1;
    for (int i = 0; i < 18; i++) cycle();
    chk("drain_credits", credit_seen - c0, 16);
    chk("drain_level", lnk.rx_fifo_level, 0);

    // full with push and pop together
    lnk.rx_phy_push = 1; lnk.user_rx_ready = 0;
    for (int i = 0; i < 16; i++) begin lnk.rx_phy_data = rnd_word(); cycle(); end
    lnk.user_rx_ready = 1; lnk.rx_phy_data = rnd_word(); cycle();
    chk("pushpop_level", lnk.rx_fifo_level, 16);
    lnk.rx_phy_push = 0;
    for (int i = 0; i < 17; i++) cycle();

    // rx_online drop with 5 words buffered
    lnk.rx_phy_push = 1; lnk.user_rx_ready = 0;
    for (int i = 0; i < 5; i++) begin lnk.rx_phy_data = rnd_word(); cycle(); end
    chk("pre_drop_level", lnk.rx_fifo_level, 5);
    c0 = credit_seen;
    lnk.rx_online = 0; lnk.user_rx_ready = 1;
    for (int i = 0; i < 3; i++) begin lnk.rx_phy_data = rnd_word(); cycle(); end
    chk("drop_level", lnk.rx_fifo_level, 0);
    chk("drop_valid", lnk.user_rx_valid, 0);
    chk("drop_credits", credit_seen - c0, 0);
    lnk.rx_phy_push = 0; lnk.user_rx_ready = 0;

    // credit saturation at 255
    lnk.tx_online = 0; cycle();
    lnk.init_upstream_credit = 8'd255; lnk.tx_online = 1; cycle();
    lnk.rx_credit_in = 1; cycle();
    lnk.rx_credit_in = 0; cycle();
    chk("sat_count", lnk.tx_credit_count, 255);
    chk("sat_ovf", lnk.tx_credit_overflow, 1);
    chk("sat_dbg30", lnk.debug_status[30], 1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      lnk.tx_online = ($urandom % 20) != 0;
      lnk.rx_online = ($urandom % 25) != 0;
      lnk.init_upstream_credit = CW'($urandom_range(0, 20));
      lnk.user_tx_valid = $urandom % 2;
      lnk.user_tx_data = rnd_word();
      lnk.rx_credit_in = ($urandom % 3) == 0;
      lnk.rx_phy_push = $urandom % 2;
      lnk.rx_phy_data = rnd_word();
      lnk.user_rx_ready = $urandom % 2;
      cycle();
    end

    // asynchronous reset in the middle of traffic
    lnk.tx_online = 1; lnk.rx_online = 1; lnk.rx_phy_push = 1;
    lnk.user_rx_ready = 0; lnk.user_tx_valid = 1;
    for (int i = 0; i < 3; i++) begin lnk.rx_phy_data = rnd_word(); cycle(); end
    #3;
    rst_n = 0;
    #1;
    chk_reset_outputs();
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_hold_credit", lnk.tx_credit_out, 0);
    rst_n = 1;
    lnk.init_upstream_credit = 8'd2;
    for (int i = 0; i < 8; i++) begin
      lnk.user_rx_ready = (i > 3);
      lnk.user_tx_data = rnd_word();
      lnk.rx_phy_data = rnd_word();
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lpif_ll_credit_fifo.md
# lpif_ll_credit_fifo

Parametrised LPIF logic-link layer that sits between the user interface and the PHY concat block, replacing the FIFO/credit bypass used by earlier half-rate tops. TX side gates user words with a credit counter loaded from `init_upstream_credit` and replenished by far-end credit pulses. RX side buffers PHY words in a `DEPTH`-entry FIFO with a valid/ready pop interface and returns one credit pulse per word consumed.

## Interface
Parameters:
- `DATA_WIDTH`, 562: LPIF logic-link word width in bits.
- `DEPTH`, 16: RX FIFO entries; power of two, at least 2.
- `CRED_WIDTH`, 8: TX credit counter width. Requires `DEPTH` <= 2^`CRED_WIDTH`-1.

Ports:
- `clk_wr` in 1: single clock; all logic is on this clock.
- `rst_wr_n` in 1: reset, asynchronous, active-low.
- `tx_online` in 1: TX link online (post auto-sync delay).
- `rx_online` in 1: RX link online (post auto-sync delay).
- `init_upstream_credit` in `CRED_WIDTH`: initial far-end buffer credits.
- `user_tx_data` in `DATA_WIDTH`: user word to transmit.
- `user_tx_valid` in 1: user word valid.
- `user_tx_ready` out 1: word accepted this cycle when high with valid.
- `tx_phy_data` out `DATA_WIDTH`: word to concat block.
- `tx_phy_push` out 1: `tx_phy_data` valid.
- `rx_credit_in` in 1: one-credit pulse from the far end.
- `rx_phy_data` in `DATA_WIDTH`: word from concat block.
- `rx_phy_push` in 1: `rx_phy_data` valid.
- `user_rx_data` out `DATA_WIDTH`: FIFO head word.
- `user_rx_valid` out 1: FIFO non-empty.
- `user_rx_ready` in 1: user consumes head.
- `tx_credit_out` out 1: one-credit pulse to far end.
- `rx_fifo_level` out $clog2(`DEPTH`)+1: RX occupancy.
- `tx_credit_count` out `CRED_WIDTH`: available TX credits.
- `rx_overflow` out 1: sticky, word dropped on full FIFO.
- `tx_credit_overflow` out 1: sticky, credit received at saturation.
- `debug_status` out 32: status word.

## Operation
- All outputs reset to 0; FIFO pointers and level reset to 0; sticky flags clear only on reset.
- TX credit counter:
  - `tx_online` is registered; when the register is 0 and `tx_online` is 1 (rising edge), the count loads `init_upstream_credit`. `rx_credit_in` that cycle is ignored.
  - While `tx_online` is 0, the count is held at 0.
  - Otherwise: +1 on `rx_credit_in`, -1 on accept. Both in the same cycle leaves the count unchanged.
  - An increment at all-ones without a decrement saturates the count and sets `tx_credit_overflow`.
- `user_tx_ready` = `tx_online` & (count != 0), combinational from registers. Accept = `user_tx_valid` & `user_tx_ready`.
- `tx_phy_push`/`tx_phy_data` are registered from the accept. When push is 0, data holds its last value.
- RX FIFO: register array with write and read pointers of $clog2(`DEPTH`) bits; pointers wrap naturally.
  - Push = `rx_phy_push` & `rx_online`.
  - Pop = `user_rx_valid` & `user_rx_ready`.
  - Push while full with no pop: word dropped, `rx_overflow` set, level unchanged.
  - Push while full with a pop: accepted, level stays `DEPTH`.
  - Push and pop in the same cycle when non-empty: level unchanged.
- `user_rx_data` = mem[rd_ptr] (first-word fall-through). `user_rx_valid` = level != 0.
- `tx_credit_out` is a registered copy of pop: exactly one pulse per consumed word.
- `rx_online` low: pointers and level cleared next edge. `user_rx_valid` and `tx_credit_out` are 0 from that edge; pushes are ignored.
- `debug_status`:
  - [31] `rx_overflow`, [30] `tx_credit_overflow`.
  - [23:16] `tx_credit_count` (zero-padded or truncated to 8 bits).
  - [15:8] `rx_fifo_level` (zero-padded).
  - [1] `tx_online`, [0] `rx_online`.
  - Other bits 0.

## Timing
- TX latency: accept at edge N produces `tx_phy_push` high in cycle N+1. Sustained throughput is 1 word/cycle while credits remain.
- Credit count and ready update the cycle after an accept or credit pulse. The last credit consumed at N gives ready 0 in N+1.
- RX latency: push at edge N gives `user_rx_valid` high in cycle N+1 with the word on `user_rx_data`.
- Pop at edge N gives `tx_credit_out` high in cycle N+1 for one cycle.
- `tx_online` falling: count 0 and ready 0 the next cycle; an in-flight `tx_phy_push` still completes.
- Asynchronous reset mid-traffic: all state clears immediately; no credit pulse is issued for discarded words.

## Test plan
- Credit load and exhaustion: `init_upstream_credit`=4, `tx_online` raised, valid held high -> exactly 4 `tx_phy_push` pulses, then ready 0, count 0. One `rx_credit_in` -> one more push.
- Simultaneous credit and accept: count=3, `rx_credit_in` with accept each cycle for 5 cycles -> count stays 3; 5 pushes with data in order.
- RX fill/drain: `DEPTH`=16, 16 pushes with `user_rx_ready`=0 -> level 16, no credits. 17th push -> dropped, `rx_overflow`=1. Then ready=1 -> 16 words in order, 16 `tx_credit_out` pulses, level 0.
- Full with push+pop same cycle: level 16, push and pop together -> level 16, no overflow, new word appears after 15 further pops.
- `rx_online` drop with level 5 -> level 0 and valid 0 next cycle, no credit pulses. Pushes while offline ignored.
- Credit saturation: `CRED_WIDTH`=8, count 255, `rx_credit_in` with no accept -> count 255, `tx_credit_overflow`=1, `debug_status`[30]=1.
